// File: rtl/adc_square_shaper_pkg.sv
// Shared types and arithmetic helpers for the ADC square-wave shaper.
// The SHAPER_SIGNED_EN build option is handled in the top-level file.
package shaper_pkg;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  function automatic logic [31:0] midscale(input int w);
    return 32'(1) << (w - 1);
  endfunction

  // Saturating add/sub on zero-extended operands; callers truncate the result to their width.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (b > a) ? 32'd0 : (a - b);
  endfunction

endpackage

// File: rtl/adc_square_shaper_if.sv
// Sample stream in, shaped square wave and threshold status out.
interface adc_square_shaper_if #(parameter int ADC_W = 12);
  logic [ADC_W-1:0] adc_data;
  logic             adc_valid;
  logic             adc_fix;
  logic             edge_rise;
  logic [ADC_W-1:0] thresh;
  logic             amp_ok;

  modport master (output adc_data, adc_valid,
                  input  adc_fix, edge_rise, thresh, amp_ok);
  modport slave  (input  adc_data, adc_valid,
                  output adc_fix, edge_rise, thresh, amp_ok);
endinterface

// File: rtl/adc_square_shaper_win_stats.sv
// Windowed min/max tracker producing the centre threshold, hysteresis and amplitude flag.
module shaper_win_stats
  import shaper_pkg::*;
#(
  parameter int ADC_W      = 12,
  parameter int WIN_LEN    = 4096,
  parameter int HYST_SHIFT = 3,
  parameter int HYST_DEF   = 16,
  parameter int MIN_AMP    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample,
  output logic [ADC_W-1:0] thresh,
  output logic [ADC_W-1:0] hyst,
  output logic             amp_ok,
  output logic             win_done
);

  localparam int CNT_W = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIN_LEN - 1);
  localparam logic [ADC_W-1:0] MIN_AMP_V = ADC_W'(MIN_AMP);

  logic [CNT_W-1:0] win_cnt;
  logic [ADC_W-1:0] min_q, max_q, min_nxt, max_nxt, span;
  logic [ADC_W:0]   sum;

  // The closing sample must be folded in before the window results are computed.
  always_comb begin
    min_nxt = (sample < min_q) ? sample : min_q;
    max_nxt = (sample > max_q) ? sample : max_q;
    span    = max_nxt - min_nxt;
    sum     = {1'b0, max_nxt} + {1'b0, min_nxt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt  <= '0;
      min_q    <= '1;
      max_q    <= '0;
      thresh   <= ADC_W'(midscale(ADC_W));
      hyst     <= ADC_W'(HYST_DEF);
      amp_ok   <= 1'b1;
      win_done <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (sample_valid) begin
        if (win_cnt == LAST_CNT) begin
          win_cnt  <= '0;
          min_q    <= '1;
          max_q    <= '0;
          thresh   <= ADC_W'(sum >> 1);
          hyst     <= span >> HYST_SHIFT;
          amp_ok   <= (span >= MIN_AMP_V);
          win_done <= 1'b1;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          min_q   <= min_nxt;
          max_q   <= max_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/adc_square_shaper.sv
// ADC square-wave shaper: adaptive threshold, hysteresis and debounce filter.
// Define SHAPER_SIGNED_EN to accept two's-complement samples.
module adc_square_shaper
  import shaper_pkg::*;
#(
  parameter int ADC_W      = 12,
  parameter int WIN_LEN    = 4096,
  parameter int HYST_SHIFT = 3,
  parameter int HYST_DEF   = 16,
  parameter int MIN_AMP    = 64,
  parameter int DEB_CNT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  adc_square_shaper_if.slave bus
);

  localparam int DEB_W = $clog2(DEB_CNT + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  logic [ADC_W-1:0] sample, thresh_w, hyst_w, hi, lo;
  logic             amp_ok_w, qualify;
  state_t           state_q, state_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             rise_q, rise_d;

`ifdef SHAPER_SIGNED_EN
  assign sample = {~bus.adc_data[ADC_W-1], bus.adc_data[ADC_W-2:0]};
`else
  assign sample = bus.adc_data;
`endif

  shaper_win_stats #(
    .ADC_W(ADC_W), .WIN_LEN(WIN_LEN), .HYST_SHIFT(HYST_SHIFT),
    .HYST_DEF(HYST_DEF), .MIN_AMP(MIN_AMP)
  ) u_stats (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (bus.adc_valid),
    .sample       (sample),
    .thresh       (thresh_w),
    .hyst         (hyst_w),
    .amp_ok       (amp_ok_w),
    .win_done     ()
  );

  assign hi = ADC_W'(sat_add(32'(thresh_w), 32'(hyst_w), 32'({ADC_W{1'b1}})));
  assign lo = ADC_W'(sat_sub(32'(thresh_w), 32'(hyst_w)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOW;
      deb_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
    end
  end

  // A low amplitude flag freezes the filter so noise around the centre cannot toggle the output.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    rise_d  = 1'b0;
    qualify = (state_q == ST_LOW) ? (sample > hi) : (sample < lo);
    if (bus.adc_valid && amp_ok_w) begin
      if (qualify) begin
        if (deb_q == DEB_LAST) begin
          state_d = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
          deb_d   = '0;
          rise_d  = (state_q == ST_LOW);
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end else begin
        deb_d = '0;
      end
    end
  end

  assign bus.adc_fix   = (state_q == ST_HIGH);
  assign bus.edge_rise = rise_q;
  assign bus.thresh    = thresh_w;
  assign bus.amp_ok    = amp_ok_w;

endmodule
